// File: rtl/ddr_burst_engine_if.sv
// Command, host data and DQ/DQS bus bundle for the DDR burst engine.
// The master side is the controller/BFM; the slave side is the engine.
interface ddr_burst_engine_if #(
    parameter int DQ_WIDTH  = 64,
    parameter int BURST_LEN = 8
);
    logic                          cmd_valid;
    logic                          cmd_ready;
    logic                          cmd_write;
    logic                          cmd_chop;
    logic [BURST_LEN*DQ_WIDTH-1:0] wr_data;
    logic [DQ_WIDTH-1:0]           dq_out;
    logic                          dq_oe;
    logic                          dqs_t;
    logic                          dqs_c;
    logic                          dqs_oe;
    logic [DQ_WIDTH-1:0]           dq_in;
    logic [BURST_LEN*DQ_WIDTH-1:0] rd_data;
    logic                          rd_valid;
    logic                          busy;

    modport master (
        output cmd_valid, cmd_write, cmd_chop, wr_data, dq_in,
        input  cmd_ready, dq_out, dq_oe, dqs_t, dqs_c, dqs_oe, rd_data, rd_valid, busy
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_chop, wr_data, dq_in,
        output cmd_ready, dq_out, dq_oe, dqs_t, dqs_c, dqs_oe, rd_data, rd_valid, busy
    );
endinterface

// File: rtl/ddr_burst_engine.sv
// DDR burst data-path engine: serialises write bursts onto DQ with DQS
// preamble/postamble, and captures read bursts after a fixed read latency.
module ddr_burst_engine #(
    parameter int DQ_WIDTH  = 64,
    parameter int BURST_LEN = 8,
    parameter int RD_LAT    = 2
) (
    input  logic                clock,
    input  logic                reset,
    ddr_burst_engine_if.slave   bus
);
    localparam int BUS_W = BURST_LEN * DQ_WIDTH;
    localparam int BW    = $clog2(BURST_LEN);
    localparam int LW    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    localparam logic [BW-1:0] LAST_FULL = BW'(BURST_LEN - 1);
    localparam logic [BW-1:0] LAST_CHOP = BW'(BURST_LEN / 2 - 1);
    localparam logic [LW-1:0] LAST_LAT  = LW'(RD_LAT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WPRE   = 3'd1,
        ST_WBURST = 3'd2,
        ST_WPOST  = 3'd3,
        ST_RWAIT  = 3'd4,
        ST_RBURST = 3'd5,
        ST_RDONE  = 3'd6
    } state_t;

    state_t              state_q;
    logic [BW-1:0]       beat_q;
    logic [BW-1:0]       beat_d;
    logic [LW-1:0]       lat_q;
    logic                chop_q;
    logic [BUS_W-1:0]    wdata_q;
    logic                cmd_ready_q;
    logic [DQ_WIDTH-1:0] dq_out_q;
    logic                dq_oe_q;
    logic                dqs_t_q;
    logic                dqs_c_q;
    logic                dqs_oe_q;
    logic [BUS_W-1:0]    rd_data_q;
    logic                rd_valid_q;
    logic [BW-1:0]       last_beat_s;

    // Beat bookkeeping: last beat index of the current burst and the next index.
    always_comb begin
        beat_d = beat_q + BW'(1);
        if (chop_q) begin
            last_beat_s = LAST_CHOP;
        end else begin
            last_beat_s = LAST_FULL;
        end
    end

    // Burst sequencer; every bus-facing output is registered here.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            lat_q       <= '0;
            chop_q      <= 1'b0;
            wdata_q     <= '0;
            cmd_ready_q <= 1'b1;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            dqs_t_q     <= 1'b0;
            dqs_c_q     <= 1'b1;
            dqs_oe_q    <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    rd_valid_q <= 1'b0;
                    if (bus.cmd_valid) begin
                        chop_q      <= bus.cmd_chop;
                        wdata_q     <= bus.wr_data;
                        beat_q      <= '0;
                        lat_q       <= '0;
                        cmd_ready_q <= 1'b0;
                        if (bus.cmd_write) begin
                            state_q  <= ST_WPRE;
                            dqs_oe_q <= 1'b1;
                            dqs_t_q  <= 1'b0;
                            dqs_c_q  <= 1'b1;
                        end else begin
                            state_q  <= ST_RWAIT;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end

                ST_WPRE: begin
                    state_q  <= ST_WBURST;
                    beat_q   <= '0;
                    dq_out_q <= wdata_q[DQ_WIDTH-1:0];
                    wdata_q  <= wdata_q >> DQ_WIDTH;
                    dq_oe_q  <= 1'b1;
                    dqs_t_q  <= 1'b1;
                    dqs_c_q  <= 1'b0;
                end

                // Strobe toggles once per beat: even beats high, odd beats low.
                ST_WBURST: begin
                    if (beat_q == last_beat_s) begin
                        state_q  <= ST_WPOST;
                        dq_out_q <= '0;
                        dq_oe_q  <= 1'b0;
                        dqs_t_q  <= 1'b0;
                        dqs_c_q  <= 1'b1;
                    end else begin
                        beat_q   <= beat_d;
                        dq_out_q <= wdata_q[DQ_WIDTH-1:0];
                        wdata_q  <= wdata_q >> DQ_WIDTH;
                        dqs_t_q  <= beat_q[0];
                        dqs_c_q  <= ~beat_q[0];
                    end
                end

                ST_WPOST: begin
                    state_q     <= ST_IDLE;
                    dqs_oe_q    <= 1'b0;
                    dqs_t_q     <= 1'b0;
                    dqs_c_q     <= 1'b1;
                    cmd_ready_q <= 1'b1;
                end

                ST_RWAIT: begin
                    if (lat_q == LAST_LAT) begin
                        state_q <= ST_RBURST;
                    end else begin
                        lat_q   <= lat_q + LW'(1);
                    end
                end

                // First capture clears the whole vector so a chopped read leaves zeros above.
                ST_RBURST: begin
                    if (beat_q == '0) begin
                        rd_data_q <= {{(BUS_W-DQ_WIDTH){1'b0}}, bus.dq_in};
                    end else begin
                        rd_data_q[int'(beat_q)*DQ_WIDTH +: DQ_WIDTH] <= bus.dq_in;
                    end
                    if (beat_q == last_beat_s) begin
                        state_q    <= ST_RDONE;
                        rd_valid_q <= 1'b1;
                    end else begin
                        beat_q     <= beat_d;
                    end
                end

                ST_RDONE: begin
                    state_q     <= ST_IDLE;
                    rd_valid_q  <= 1'b0;
                    cmd_ready_q <= 1'b1;
                end

                default: begin
                    state_q     <= ST_IDLE;
                    beat_q      <= '0;
                    lat_q       <= '0;
                    cmd_ready_q <= 1'b1;
                    dq_out_q    <= '0;
                    dq_oe_q     <= 1'b0;
                    dqs_t_q     <= 1'b0;
                    dqs_c_q     <= 1'b1;
                    dqs_oe_q    <= 1'b0;
                    rd_valid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.busy      = ~cmd_ready_q;
    assign bus.dq_out    = dq_out_q;
    assign bus.dq_oe     = dq_oe_q;
    assign bus.dqs_t     = dqs_t_q;
    assign bus.dqs_c     = dqs_c_q;
    assign bus.dqs_oe    = dqs_oe_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
endmodule
